// File: rtl/usb_rx_pkt_parser.sv
// USB receive packet parser: classifies packets from the byte-level receiver,
// decodes token/SOF fields, validates handshakes and streams data payload with
// the trailing CRC16 bytes stripped by a 2-deep holding pipeline.
module usb_rx_pkt_parser #(
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 11
) (
  input  logic        clk_48,
  input  logic        rst,
  input  logic [6:0]  dev_addr,
  input  logic [3:0]  xpid,
  input  logic [7:0]  xdata,
  input  logic        xpacket,
  input  logic        xdatastrobe,
  input  logic        xcrc5_ok,
  input  logic        xcrc16_ok,
  output logic        tok_valid,
  output logic [3:0]  tok_pid,
  output logic [3:0]  tok_endp,
  output logic        sof_valid,
  output logic [10:0] sof_frame,
  output logic        hs_valid,
  output logic [3:0]  hs_pid,
  output logic        rx_start,
  output logic [3:0]  rx_pid,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_end,
  output logic        rx_ok
);

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_DATA, S_DEND, S_HSHAKE, S_DISCARD
  } state_t;

  state_t           state;
  logic             xpacket_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] emitted;
  logic [3:0]       pid;
  logic             is_sof;
  logic [7:0]       b0;
  logic [2:0]       b1;
  logic             crc5;
  logic             crc16;
  logic [7:0]       h0, h1;
  logic             ovf;
  logic             pend_ok;

  logic             sop;
  logic [CNT_W-1:0] cnt_nx;
  logic [7:0]       b0_nx;
  logic [2:0]       b1_nx;
  logic             crc5_nx, crc16_nx;
  logic             tok_good;
  logic             emit, at_max, ovf_nx, data_ok;

  assign sop = xpacket & ~xpacket_d;

  // Byte-first view of the packet state: lets end-of-packet evaluation see a
  // byte that arrives in the same cycle xpacket falls.
  always_comb begin
    cnt_nx   = cnt;
    b0_nx    = b0;
    b1_nx    = b1;
    crc5_nx  = crc5;
    crc16_nx = crc16;
    if (xdatastrobe) begin
      if (cnt != {CNT_W{1'b1}}) cnt_nx = cnt + CNT_W'(1);
      if (cnt == CNT_W'(0)) b0_nx = xdata;
      if (cnt == CNT_W'(1)) begin
        b1_nx   = xdata[2:0];
        crc5_nx = xcrc5_ok;
      end
      crc16_nx = xcrc16_ok;
    end
    tok_good = (cnt_nx == CNT_W'(2)) && crc5_nx && (is_sof || (b0_nx[6:0] == dev_addr));
    // Once two bytes are held, each new byte pushes the oldest one out as payload.
    emit     = xdatastrobe && (cnt >= CNT_W'(2));
    at_max   = (emitted == CNT_W'(MAX_LEN));
    ovf_nx   = ovf | (emit & at_max);
    data_ok  = crc16_nx & (cnt_nx >= CNT_W'(2)) & ~ovf_nx;
  end

  // Packet FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk_48) begin
    if (rst) begin
      state     <= S_IDLE;
      xpacket_d <= 1'b1;
      cnt       <= '0;
      emitted   <= '0;
      pid       <= '0;
      is_sof    <= 1'b0;
      b0        <= '0;
      b1        <= '0;
      crc5      <= 1'b0;
      crc16     <= 1'b0;
      h0        <= '0;
      h1        <= '0;
      ovf       <= 1'b0;
      pend_ok   <= 1'b0;
      tok_valid <= 1'b0;
      tok_pid   <= '0;
      tok_endp  <= '0;
      sof_valid <= 1'b0;
      sof_frame <= '0;
      hs_valid  <= 1'b0;
      hs_pid    <= '0;
      rx_start  <= 1'b0;
      rx_pid    <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_end    <= 1'b0;
      rx_ok     <= 1'b0;
    end else begin
      xpacket_d <= xpacket;
      tok_valid <= 1'b0;
      sof_valid <= 1'b0;
      hs_valid  <= 1'b0;
      rx_start  <= 1'b0;
      rx_valid  <= 1'b0;
      rx_end    <= 1'b0;
      rx_ok     <= 1'b0;
      case (state)
        S_IDLE: if (sop) begin
          cnt     <= '0;
          emitted <= '0;
          pid     <= xpid;
          is_sof  <= 1'b0;
          crc5    <= 1'b0;
          crc16   <= 1'b0;
          ovf     <= 1'b0;
          if (xpid[1:0] == 2'b11) begin
            state    <= S_DATA;
            rx_start <= 1'b1;
            rx_pid   <= xpid;
          end else if (xpid == 4'b0001 || xpid == 4'b1001 || xpid == 4'b1101) begin
            state <= S_TOKEN;
          end else if (xpid == 4'b0101) begin
            state  <= S_TOKEN;
            is_sof <= 1'b1;
          end else if (xpid == 4'b0010 || xpid == 4'b1010 ||
                       xpid == 4'b1110 || xpid == 4'b0110) begin
            state <= S_HSHAKE;
          end else begin
            state <= S_DISCARD;
          end
        end
        S_TOKEN: begin
          cnt  <= cnt_nx;
          b0   <= b0_nx;
          b1   <= b1_nx;
          crc5 <= crc5_nx;
          if (!xpacket) begin
            state <= S_IDLE;
            if (tok_good) begin
              if (is_sof) begin
                sof_valid <= 1'b1;
                sof_frame <= {b1_nx, b0_nx};
              end else begin
                tok_valid <= 1'b1;
                tok_pid   <= pid;
                tok_endp  <= {b1_nx, b0_nx[7]};
              end
            end
          end
        end
        S_DATA: begin
          cnt <= cnt_nx;
          if (xdatastrobe) begin
            h0    <= h1;
            h1    <= xdata;
            crc16 <= xcrc16_ok;
          end
          if (emit) begin
            if (at_max) ovf <= 1'b1;
            else begin
              rx_valid <= 1'b1;
              rx_data  <= h0;
              emitted  <= emitted + CNT_W'(1);
            end
          end
          if (!xpacket) begin
            // A payload byte leaving on the final cycle defers rx_end by one
            // so rx_valid and rx_end never overlap.
            if (emit && !at_max) begin
              state   <= S_DEND;
              pend_ok <= data_ok;
            end else begin
              state  <= S_IDLE;
              rx_end <= 1'b1;
              rx_ok  <= data_ok;
            end
          end
        end
        S_DEND: begin
          state  <= S_IDLE;
          rx_end <= 1'b1;
          rx_ok  <= pend_ok;
        end
        S_HSHAKE: begin
          cnt <= cnt_nx;
          if (!xpacket) begin
            state <= S_IDLE;
            if (cnt_nx == CNT_W'(0)) begin
              hs_valid <= 1'b1;
              hs_pid   <= pid;
            end
          end
        end
        S_DISCARD: if (!xpacket) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
